tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter ADDRW, default 8, address width per request.
REQ-002 SHALL have parameter OPCODEW, default 2, opcode width per request.
REQ-003 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req_valid  input  NREQ  bit i: requester i holds a pending command.
REQ-007 SHALL have port req_opcode  input  NREQ*OPCODEW  slice i = bits [i*OPCODEW +: OPCODEW].
REQ-008 SHALL have port req_addr  input  NREQ*ADDRW  slice i = bits [i*ADDRW +: ADDRW].
REQ-009 SHALL have port req_ready  output  NREQ  one-hot-or-zero accept strobe per requester.
REQ-010 SHALL have port ser_valid  output  1  command presented to serializer.
REQ-011 SHALL have port ser_opcode  output  OPCODEW  opcode to serializer.
REQ-012 SHALL have port ser_addr  output  ADDRW  address to serializer.
REQ-013 SHALL have port ser_ready  input  1  serializer idle/ready flag; drops after capture, rises when shifting is complete.
REQ-014 SHALL have port grant_id  output  clog2(NREQ), min 1  index of the requester currently being served.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port issued_cnt  output  8  count of completed serializer transfers, wraps 255->0.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT_LOW, and WAIT_HIGH.
REQ-018 In IDLE, SHALL select the winner by round-robin: first i with req_valid[i] set, scanning ptr, ptr+1, ... mod NREQ.
REQ-019 SHALL drive req_ready[winner] combinationally high only in IDLE while any req_valid is set; all other bits SHALL be 0.
REQ-020 On an accept edge (IDLE, req_valid[w]&req_ready[w]), SHALL latch slice w into ser_opcode/ser_addr, set grant_id<=w, ptr<=(w+1) mod NREQ, and go to ISSUE.
REQ-021 In ISSUE, ser_valid SHALL be 1 and ser_opcode/ser_addr/grant_id SHALL be held stable.
REQ-022 ISSUE->WAIT_LOW SHALL occur on the edge where ser_valid&ser_ready; ser_valid SHALL be 0 from the next cycle.
REQ-023 WAIT_LOW->WAIT_HIGH SHALL occur on the first edge with ser_ready==0.
REQ-024 WAIT_LOW SHALL have a 2-cycle timeout: if ser_ready stays high for 2 edges, SHALL proceed as if complete to IDLE and increment issued_cnt.
REQ-025 WAIT_HIGH->IDLE SHALL occur on the first edge with ser_ready==1, incrementing issued_cnt on that edge.
REQ-026 Minimum spacing SHALL be: accept at T0, ser_valid high T0+1..capture, next accept no earlier than one cycle after returning to IDLE.
REQ-027 Requests arriving or withdrawn outside IDLE SHALL be ignored, and a latched command SHALL never be altered.
REQ-028 With simultaneous requests, SHALL serve each valid requester exactly once per NREQ grants (no starvation).
REQ-029 If req_valid drops in IDLE before acceptance, SHALL take no action and leave ptr unchanged.

Reset
REQ-030 On any edge with rst_n==0, regardless of state, SHALL set state=IDLE, ser_valid=0, ser_opcode=0, ser_addr=0, grant_id=0, ptr=0, issued_cnt=0.
REQ-031 While rst_n==0, req_ready SHALL be 0 and busy SHALL be 0.
REQ-032 Reset mid-transfer SHALL abandon the in-flight command with no replay after release.

Verification
REQ-033 Single request: req_valid=0001, opcode 2'b10, addr 8'hA5, ser_ready=1 -> req_ready=0001 at T0; ser_valid=1 with {10,A5} at T0+1; ser_ready low 1 cycle later, then high -> IDLE, issued_cnt=1.
REQ-034 Contention: req_valid=1111 held -> grant_id sequence 0,1,2,3,0, with exactly one req_ready per accept.
REQ-035 Pointer: after grant to 2, req_valid=0101 -> grant 0 before... SHALL verify grant 0 (scan 3,0); next grant 2.
REQ-036 Backpressure: ser_ready=0 for 20 cycles in ISSUE -> ser_valid stays 1, payload stable, no req_ready pulses.
REQ-037 Timeout: ser_ready held 1 after capture -> IDLE after 2 edges in WAIT_LOW, issued_cnt incremented.
REQ-038 Reset in WAIT_HIGH with issued_cnt=255 -> all outputs per REQ-030; wrap check separately: 256 transfers -> issued_cnt=0.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter feeding one command at a time to a serializer
module tx_arbiter #(
  parameter int ADDRW = 8,
  parameter int OPCODEW = 2,
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*OPCODEW-1:0]  req_opcode,
  input  logic [NREQ*ADDRW-1:0]    req_addr,
  output logic [NREQ-1:0]          req_ready,
  output logic                     ser_valid,
  output logic [OPCODEW-1:0]       ser_opcode,
  output logic [ADDRW-1:0]         ser_addr,
  input  logic                     ser_ready,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic [7:0]               issued_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;
  state_t state;
  logic [IDW-1:0] ptr, win;
  logic found, tmo;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win = IDW'((int'(ptr) + k) % NREQ);
      end
  end
  assign req_ready = (rst_n && state == IDLE && found) ? NREQ'(1) << win : '0;
  assign busy = rst_n && state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ser_valid <= 1'b0;
      ser_opcode <= '0;
      ser_addr <= '0;
      grant_id <= '0;
      ptr <= '0;
      tmo <= 1'b0;
      issued_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          ser_opcode <= req_opcode[int'(win)*OPCODEW +: OPCODEW];
          ser_addr <= req_addr[int'(win)*ADDRW +: ADDRW];
          grant_id <= win;
          ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          ser_valid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (ser_ready) begin
          ser_valid <= 1'b0;
          tmo <= 1'b0;
          state <= WAIT_LOW;
        end
        // a serializer that never drops ready is treated as done after two edges
        WAIT_LOW: if (!ser_ready) state <= WAIT_HIGH;
          else if (tmo) begin
            state <= IDLE;
            issued_cnt <= issued_cnt + 8'd1;
          end else tmo <= 1'b1;
        WAIT_HIGH: if (ser_ready) begin
          state <= IDLE;
          issued_cnt <= issued_cnt + 8'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed stimulus with a capture scoreboard for tx_arbiter
module tb_tx_arbiter;
  logic clk = 1'b0, rst_n, ser_ready;
  logic [3:0] req_valid, req_ready;
  logic [7:0] req_opcode;
  logic [31:0] req_addr;
  logic ser_valid, busy;
  logic [1:0] ser_opcode, grant_id;
  logic [7:0] ser_addr, issued_cnt;
  logic [9:0] pl [4] = '{10'h2A5, 10'h111, 10'h212, 10'h313};
  logic [11:0] exp_q [$];
  int n_cmp = 0, n_err = 0, lo = 1;
  tx_arbiter #(.ADDRW(8), .OPCODEW(2), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_ready(req_ready), .ser_valid(ser_valid),
    .ser_opcode(ser_opcode), .ser_addr(ser_addr), .ser_ready(ser_ready),
    .grant_id(grant_id), .busy(busy), .issued_cnt(issued_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_cnt(input logic [7:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (issued_cnt == target) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_cnt: issued_cnt %0d never reached %0d", issued_cnt, target);
  endtask
  task automatic push(input logic [1:0] id);
    exp_q.push_back({id, pl[id]});
  endtask
  // monitor: every accept strobe must be one-hot on a requesting bit; every capture pops the scoreboard
  always @(negedge clk) if (rst_n) begin
    if (req_ready != 4'd0)
      chk("onehot_ready", 32'(($onehot(req_ready) && (req_ready & req_valid) == req_ready)), 1);
    if (ser_valid && ser_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL capture: unexpected {%0d,%0h,%0h}", grant_id, ser_opcode, ser_addr);
      end else chk("capture", {grant_id, ser_opcode, ser_addr}, 32'(exp_q.pop_front()));
    end
  end
  // serializer model: after a capture, ready drops for lo cycles (lo==0: never drops)
  always begin
    @(negedge clk);
    if (rst_n && ser_valid && ser_ready && lo > 0) begin
      @(posedge clk);
      #1 ser_ready = 1'b0;
      repeat (lo) @(posedge clk);
      #1 ser_ready = 1'b1;
    end
  end
  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    ser_ready = 1'b1;
    for (int i = 0; i < 4; i++) {req_opcode[i*2 +: 2], req_addr[i*8 +: 8]} = pl[i];
    repeat (2) tick();
    req_valid = 4'hF;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_payload", {grant_id, ser_opcode, ser_addr}, 0);
    chk("rst_cnt", issued_cnt, 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    req_valid = 4'b0001;
    push(0);
    #1 chk("t0_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_valid", ser_valid, 1);
    chk("t1_busy", busy, 1);
    wait_cnt(1, 20);
    chk("single_cnt", issued_cnt, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) push(2'(g));
    req_valid = 4'hF;
    wait_cnt(5, 60);
    req_valid = '0;
    push(2);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_cnt(6, 20);
    push(0);
    push(2);
    req_valid = 4'b0101;
    wait_cnt(8, 40);
    req_valid = '0;
    ser_ready = 1'b0;
    push(1);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'hF;
    repeat (20) begin
      tick();
      chk("bp_valid", ser_valid, 1);
      chk("bp_payload", {grant_id, ser_opcode, ser_addr}, {2'd1, pl[1]});
      chk("bp_ready", req_ready, 0);
    end
    req_valid = '0;
    ser_ready = 1'b1;
    wait_cnt(9, 20);
    lo = 0;
    push(0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    chk("to_busy_a", busy, 1);
    chk("to_cnt_a", issued_cnt, 9);
    tick();
    chk("to_busy_b", busy, 1);
    chk("to_cnt_b", issued_cnt, 9);
    tick();
    chk("to_busy_c", busy, 0);
    chk("to_cnt_c", issued_cnt, 10);
    lo = 1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int g = 0; g < 255; g++) push(0);
    req_valid = 4'b0001;
    wait_cnt(255, 2000);
    req_valid = '0;
    chk("cnt_255", issued_cnt, 255);
    lo = 3;
    push(0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("wh_busy", busy, 1);
    chk("wh_valid", ser_valid, 0);
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", req_ready, 0);
    tick();
    chk("rst_mid_payload", {grant_id, ser_valid, ser_opcode, ser_addr}, 0);
    chk("rst_mid_cnt", issued_cnt, 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("no_replay_valid", ser_valid, 0);
    chk("no_replay_cnt", issued_cnt, 0);
    lo = 1;
    for (int g = 0; g < 256; g++) push(0);
    req_valid = 4'b0001;
    wait_cnt(255, 2000);
    wait_cnt(0, 20);
    req_valid = '0;
    chk("wrap_cnt", issued_cnt, 0);
    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
